cnn_ctrl_seq: RTL

Parametrised CNN frame sequencer between the AXI register bank and the CNN core. It synchronises and edge-detects the control register, buffers pixels written by the MicroBlaze in a FIFO, and streams exactly one frame of pixels to the CNN with a valid/ready handshake. It then waits for the CNN result with a timeout watchdog, keeps a frame counter, and records sticky error codes.

---
 rtl/cnn_ctrl_seq.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_ctrl_seq.sv
`default_nettype none
// cnn_ctrl_seq - CNN frame sequencer: control sync, pixel FIFO, one-frame streaming, watchdog, errors.
// Optional feature macro: CNN_CTRL_PERF_EN (adds perf_cycles_reg). Revision 1.0
module cnn_ctrl_seq #(
  parameter int PIX_W            = 8,
  parameter int PIXELS_PER_FRAME = 1024,
  parameter int FIFO_DEPTH       = 16,
  parameter int TIMEOUT_CYCLES   = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       control_reg,
  input  logic [31:0]       pixel_reg,
  input  logic              pixel_wr,
  output logic [31:0]       status_reg,
  output logic [31:0]       frame_count_reg,
  output logic [31:0]       error_code_reg,
  output logic              cnn_start,
  output logic              cnn_reset,
  input  logic              cnn_busy,
  input  logic              cnn_result_valid,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  input  logic              pix_ready,
`ifdef CNN_CTRL_PERF_EN
  output logic [31:0]       perf_cycles_reg,
`endif
  output logic              frame_start,
  output logic              frame_complete
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        ctrl_s1_q, ctrl_s2_q, ctrl_prev_q;
  logic              res_prev_q;
  logic [PIX_W-1:0]  mem_q [FIFO_DEPTH];
  logic [LW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [31:0]       pix_cnt_q, pix_cnt_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       frame_cnt_q;
  logic [2:0]        err_q, err_d;
  logic [31:0]       status_q, status_d;
  logic              cnn_start_q, cnn_start_d;
  logic              cnn_reset_q, cnn_reset_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_complete_q, frame_complete_d;

  logic              start_cmd, abort_cmd, clr_cmd;
  logic              res_rise;
  logic [LW-1:0]     fifo_level;
  logic              fifo_empty, fifo_full;
  logic              pop_ok, pop_fire, push_ok, overflow;
  logic              flush, wd_hit, frame_done;
  logic              err_start, err_tmo;
  logic              unused_ok;

  assign unused_ok = ^{control_reg[31:3], pixel_reg};

  assign start_cmd = ctrl_s2_q[0] & ~ctrl_prev_q[0];
  assign abort_cmd = ctrl_s2_q[1] & ~ctrl_prev_q[1];
  assign clr_cmd   = ctrl_s2_q[2] & ~ctrl_prev_q[2];
  assign res_rise  = cnn_result_valid & ~res_prev_q;

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));

  // A flush discards both the pending pop and any same-cycle push without flagging overflow.
  assign pop_ok   = (state_q == LOAD) & ~fifo_empty & pix_ready;
  assign pop_fire = pop_ok & ~flush;
  assign push_ok  = pixel_wr & ~flush & (~fifo_full | pop_fire);
  assign overflow = pixel_wr & ~flush & fifo_full & ~pop_fire;

  assign wd_hit = (state_q != IDLE) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_s1_q   <= '0;
      ctrl_s2_q   <= '0;
      ctrl_prev_q <= '0;
      res_prev_q  <= 1'b0;
    end else begin
      ctrl_s1_q   <= control_reg[2:0];
      ctrl_s2_q   <= ctrl_s1_q;
      ctrl_prev_q <= ctrl_s2_q;
      res_prev_q  <= cnn_result_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= pixel_reg[PIX_W-1:0];
        wr_ptr_q                <= wr_ptr_q + LW'(1);
      end
      if (pop_fire) begin
        rd_ptr_q <= rd_ptr_q + LW'(1);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    pix_cnt_d        = pix_cnt_q;
    wd_d             = wd_q;
    flush            = 1'b0;
    cnn_start_d      = 1'b0;
    cnn_reset_d      = 1'b0;
    frame_start_d    = 1'b0;
    frame_complete_d = 1'b0;
    frame_done       = 1'b0;
    err_start        = 1'b0;
    err_tmo          = 1'b0;

    // Abort overrides everything: a same-cycle start or timeout leaves no trace.
    if (abort_cmd) begin
      state_d     = IDLE;
      flush       = 1'b1;
      cnn_reset_d = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (wd_hit) begin
            err_tmo     = 1'b1;
            cnn_reset_d = 1'b1;
            flush       = 1'b1;
            state_d     = IDLE;
          end else if (pop_ok) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
            wd_d      = '0;
            if (pix_cnt_q == 32'(PIXELS_PER_FRAME - 1)) begin
              frame_complete_d = 1'b1;
              state_d          = WAIT;
            end
          end else begin
            wd_d = wd_q + 32'd1;
          end
        end
        WAIT: begin
          if (wd_hit) begin
            err_tmo     = 1'b1;
            cnn_reset_d = 1'b1;
            flush       = 1'b1;
            state_d     = IDLE;
          end else if (res_rise) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            wd_d = wd_q + 32'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase

      if (start_cmd) begin
        if (state_q == IDLE && !cnn_busy) begin
          state_d       = LOAD;
          cnn_start_d   = 1'b1;
          frame_start_d = 1'b1;
          pix_cnt_d     = '0;
          wd_d          = '0;
        end else begin
          err_start = 1'b1;
        end
      end
    end
  end

  // Error sets are applied after the clear so a simultaneous event is never lost.
  always_comb begin
    err_d = err_q;
    if (clr_cmd) begin
      err_d = '0;
    end
    err_d[0] = err_d[0] | err_tmo;
    err_d[1] = err_d[1] | err_start;
    err_d[2] = err_d[2] | overflow;
  end

  always_comb begin
    status_d = {pix_cnt_q[15:0], 8'(fifo_level), 1'b0, (err_q != 3'b000),
                state_q, fifo_full, fifo_empty, cnn_result_valid, cnn_busy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pix_cnt_q        <= '0;
      wd_q             <= '0;
      frame_cnt_q      <= '0;
      err_q            <= '0;
      status_q         <= '0;
      cnn_start_q      <= 1'b0;
      cnn_reset_q      <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_complete_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pix_cnt_q        <= pix_cnt_d;
      wd_q             <= wd_d;
      err_q            <= err_d;
      status_q         <= status_d;
      cnn_start_q      <= cnn_start_d;
      cnn_reset_q      <= cnn_reset_d;
      frame_start_q    <= frame_start_d;
      frame_complete_q <= frame_complete_d;
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
    end
  end

`ifdef CNN_CTRL_PERF_EN
  logic [31:0] perf_run_q, perf_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_run_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      if (cnn_start_d) begin
        perf_run_q <= '0;
      end else if (state_q != IDLE && perf_run_q != 32'hFFFF_FFFF) begin
        perf_run_q <= perf_run_q + 32'd1;
      end
      if (frame_done) begin
        perf_cycles_q <= perf_run_q;
      end
    end
  end

  assign perf_cycles_reg = perf_cycles_q;
`endif

  assign status_reg      = status_q;
  assign frame_count_reg = frame_cnt_q;
  assign error_code_reg  = {29'd0, err_q};
  assign cnn_start       = cnn_start_q;
  assign cnn_reset       = cnn_reset_q;
  assign frame_start     = frame_start_q;
  assign frame_complete  = frame_complete_q;
  assign pix_valid       = (state_q == LOAD) & ~fifo_empty;
  assign pix_data        = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire
